// File: rtl/vegeta_weight_loader.sv
// Weight feeder for the vegeta_pu column chain: streams one tile of NUM_ROWS
// sparse weight beats into the PUs and tracks double-buffer occupancy.
module vegeta_weight_loader #(
  parameter int BETA           = 4,
  parameter int MUL_DATAWIDTH  = 8,
  parameter int META_DATA_SIZE = 2,
  parameter int BLOCK_SIZE     = 4,
  parameter int NUM_ROWS       = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           s_valid,
  output logic                                           s_ready,
  input  logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] s_data,
  input  logic                                           buf_release,
  input  logic                                           buf_release_sel,
  output logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
  output logic                                           weight_transferring_out,
  output logic                                           wb_sel_out,
  output logic [1:0]                                     buf_full,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           meta_err
);

  localparam int LW = MUL_DATAWIDTH + META_DATA_SIZE;
  localparam int CW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUF, LOAD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] row_cnt;
  logic          hs;
  logic          last_row;
  logic          meta_bad;
  logic [1:0]    full_nxt;
  logic [31:0]   lane_meta;

  assign hs       = s_valid & s_ready;
  assign last_row = (row_cnt == CW'(NUM_ROWS - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    meta_bad  = 1'b0;
    lane_meta = '0;
    for (int unsigned i = 0; i < BETA; i++) begin
      lane_meta = '0;
      lane_meta[META_DATA_SIZE-1:0] = s_data[i*LW+MUL_DATAWIDTH +: META_DATA_SIZE];
      if (lane_meta >= 32'(BLOCK_SIZE)) meta_bad = 1'b1;
    end
  end

  // Set is applied after the release so a same-buffer collision in DONE keeps the buffer full.
  always_comb begin
    full_nxt = buf_full;
    if (buf_release) full_nxt[buf_release_sel] = 1'b0;
    if (state == DONE) full_nxt[wb_sel_out] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      row_cnt                 <= '0;
      s_ready                 <= 1'b0;
      weight_out              <= '0;
      weight_transferring_out <= 1'b0;
      wb_sel_out              <= 1'b0;
      buf_full                <= '0;
      done                    <= 1'b0;
      meta_err                <= 1'b0;
    end else begin
      buf_full                <= full_nxt;
      weight_transferring_out <= 1'b0;
      done                    <= 1'b0;
      if (hs) begin
        weight_out              <= s_data;
        weight_transferring_out <= 1'b1;
        if (meta_bad) meta_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) state <= buf_full[wb_sel_out] ? WAIT_BUF : LOAD;
        end
        WAIT_BUF: begin
          if (!buf_full[wb_sel_out]) state <= LOAD;
        end
        LOAD: begin
          s_ready <= 1'b1;
          if (hs) begin
            if (last_row) begin
              row_cnt <= '0;
              s_ready <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          wb_sel_out <= ~wb_sel_out;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vegeta_weight_loader.sv
// Directed bench for vegeta_weight_loader: per-cycle vector table plus
// hand-written reset-abort and metadata sequences.
module tb_vegeta_weight_loader;

  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          buf_release;
  logic          buf_release_sel;
  logic [DW-1:0] weight_out;
  logic          weight_transferring_out;
  logic          wb_sel_out;
  logic [1:0]    buf_full;
  logic          busy;
  logic          done;
  logic          meta_err;

  int errors = 0;
  int checks = 0;

  vegeta_weight_loader #(
    .BETA(4), .MUL_DATAWIDTH(8), .META_DATA_SIZE(2), .BLOCK_SIZE(3), .NUM_ROWS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .buf_release(buf_release), .buf_release_sel(buf_release_sel),
    .weight_out(weight_out), .weight_transferring_out(weight_transferring_out),
    .wb_sel_out(wb_sel_out), .buf_full(buf_full), .busy(busy), .done(done),
    .meta_err(meta_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st, sv;
    logic [DW-1:0] dat;
    logic          rl, rs;
    logic          e_rdy, e_wt;
    logic [DW-1:0] e_wo;
    logic          e_done, e_sel;
    logic [1:0]    e_full;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] bt(input logic [7:0] v);
    return {4{2'b00, v}};
  endfunction

  function automatic vec_t mk(input logic st, sv, input logic [DW-1:0] dat, input logic rl, rs,
                              input logic e_rdy, e_wt, input logic [DW-1:0] e_wo,
                              input logic e_done, e_sel, input logic [1:0] e_full,
                              input logic e_busy);
    vec_t v;
    v.st = st; v.sv = sv; v.dat = dat; v.rl = rl; v.rs = rs;
    v.e_rdy = e_rdy; v.e_wt = e_wt; v.e_wo = e_wo; v.e_done = e_done;
    v.e_sel = e_sel; v.e_full = e_full; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, sv, input logic [DW-1:0] d, input logic rl, rs);
    @(negedge clk);
    start = st; s_valid = sv; s_data = d; buf_release = rl; buf_release_sel = rs;
  endtask

  logic [DW-1:0] bad;

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    buf_release = 1'b0; buf_release_sel = 1'b0;

    // start, sv, dat, rel, rsel | rdy, wt, wout, done, sel, full, busy
    vecs.push_back(mk(1,0,'0,0,0,      0,0,'0,0,0,2'b00,0));
    vecs.push_back(mk(0,1,bt(8'h11),0,0, 0,0,'0,0,0,2'b00,1));
    vecs.push_back(mk(0,1,bt(8'h11),0,0, 1,0,'0,0,0,2'b00,1));
    vecs.push_back(mk(0,1,bt(8'h22),0,0, 1,1,bt(8'h11),0,0,2'b00,1));
    vecs.push_back(mk(0,1,bt(8'h33),0,0, 1,1,bt(8'h22),0,0,2'b00,1));
    vecs.push_back(mk(0,1,bt(8'h44),0,0, 1,1,bt(8'h33),0,0,2'b00,1));
    vecs.push_back(mk(0,0,'0,0,0,      0,1,bt(8'h44),1,0,2'b00,1));
    vecs.push_back(mk(1,0,'0,0,0,      0,0,bt(8'h44),0,1,2'b01,0));
    vecs.push_back(mk(0,0,'0,0,0,      0,0,bt(8'h44),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'h55),0,0, 1,0,bt(8'h44),0,1,2'b01,1));
    vecs.push_back(mk(0,0,bt(8'h99),0,0, 1,1,bt(8'h55),0,1,2'b01,1));
    vecs.push_back(mk(0,0,bt(8'h99),0,0, 1,0,bt(8'h55),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'h66),0,0, 1,0,bt(8'h55),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'h77),0,0, 1,1,bt(8'h66),0,1,2'b01,1));
    vecs.push_back(mk(0,0,bt(8'h99),0,0, 1,1,bt(8'h77),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'h88),0,0, 1,0,bt(8'h77),0,1,2'b01,1));
    vecs.push_back(mk(0,0,'0,0,0,      0,1,bt(8'h88),1,1,2'b01,1));
    vecs.push_back(mk(1,0,'0,0,0,      0,0,bt(8'h88),0,0,2'b11,0));
    vecs.push_back(mk(0,0,'0,1,0,      0,0,bt(8'h88),0,0,2'b11,1));
    vecs.push_back(mk(0,0,'0,0,0,      0,0,bt(8'h88),0,0,2'b10,1));
    vecs.push_back(mk(1,0,'0,0,0,      0,0,bt(8'h88),0,0,2'b10,1));
    vecs.push_back(mk(0,1,bt(8'hA1),0,0, 1,0,bt(8'h88),0,0,2'b10,1));
    vecs.push_back(mk(1,1,bt(8'hA2),0,0, 1,1,bt(8'hA1),0,0,2'b10,1));
    vecs.push_back(mk(0,1,bt(8'hA3),0,0, 1,1,bt(8'hA2),0,0,2'b10,1));
    vecs.push_back(mk(0,1,bt(8'hA4),0,0, 1,1,bt(8'hA3),0,0,2'b10,1));
    vecs.push_back(mk(0,1,bt(8'hBB),1,1, 0,1,bt(8'hA4),1,0,2'b10,1));
    vecs.push_back(mk(0,0,'0,1,1,      0,0,bt(8'hA4),0,1,2'b01,0));
    vecs.push_back(mk(1,0,'0,0,0,      0,0,bt(8'hA4),0,1,2'b01,0));
    vecs.push_back(mk(0,0,'0,0,0,      0,0,bt(8'hA4),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'hC1),0,0, 1,0,bt(8'hA4),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'hC2),0,0, 1,1,bt(8'hC1),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'hC3),0,0, 1,1,bt(8'hC2),0,1,2'b01,1));
    vecs.push_back(mk(0,1,bt(8'hC4),0,0, 1,1,bt(8'hC3),0,1,2'b01,1));
    vecs.push_back(mk(0,0,'0,1,1,      0,1,bt(8'hC4),1,1,2'b01,1));
    vecs.push_back(mk(0,0,'0,0,0,      0,0,bt(8'hC4),0,0,2'b11,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wout", weight_out, '0);
    chk("rst_rdy", s_ready, 0);
    chk("rst_full", buf_full, 0);
    chk("rst_sel", wb_sel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_merr", meta_err, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].sv, vecs[i].dat, vecs[i].rl, vecs[i].rs);
      chk($sformatf("c%0d_rdy", i),  s_ready, vecs[i].e_rdy);
      chk($sformatf("c%0d_wt", i),   weight_transferring_out, vecs[i].e_wt);
      chk($sformatf("c%0d_wout", i), weight_out, vecs[i].e_wo);
      chk($sformatf("c%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("c%0d_sel", i),  wb_sel_out, vecs[i].e_sel);
      chk($sformatf("c%0d_full", i), buf_full, vecs[i].e_full);
      chk($sformatf("c%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("c%0d_merr", i), meta_err, 0);
    end

    // Reset in the middle of a load
    step(0,0,'0,0,0);
    rst = 1'b1; #1;
    chk("clr_full", buf_full, 0);
    #1 rst = 1'b0;
    step(1,0,'0,0,0);
    step(0,0,'0,0,0);
    step(0,1,bt(8'h31),0,0);
    chk("mid_rdy", s_ready, 1);
    step(0,1,bt(8'h32),0,0);
    chk("mid_wout1", weight_out, bt(8'h31));
    step(0,0,'0,0,0);
    chk("mid_wout2", weight_out, bt(8'h32));
    chk("mid_wt", weight_transferring_out, 1);
    #2 rst = 1'b1; #1;
    chk("abort_wout", weight_out, '0);
    chk("abort_wt", weight_transferring_out, 0);
    chk("abort_rdy", s_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sel", wb_sel_out, 0);
    chk("abort_full", buf_full, 0);
    #1 rst = 1'b0;

    // Fresh load with an illegal metadata value (3 >= BLOCK_SIZE) in lane 2
    bad = bt(8'h42);
    bad[2*10+8 +: 2] = 2'b11;
    step(1,0,'0,0,0);
    chk("m_busy0", busy, 0);
    step(0,0,'0,0,0);
    chk("m_busy1", busy, 1);
    step(0,1,bt(8'h41),0,0);
    chk("m_rdy", s_ready, 1);
    step(0,1,bad,0,0);
    chk("m_merr0", meta_err, 0);
    step(0,1,bt(8'h43),0,0);
    chk("m_wout_bad", weight_out, bad);
    chk("m_merr1", meta_err, 1);
    step(0,1,bt(8'h44),0,0);
    chk("m_wout3", weight_out, bt(8'h43));
    step(0,0,'0,0,0);
    chk("m_done", done, 1);
    chk("m_wout4", weight_out, bt(8'h44));
    step(0,0,'0,0,0);
    chk("m_full", buf_full, 2'b01);
    chk("m_sel", wb_sel_out, 1);
    chk("m_sticky", meta_err, 1);
    step(0,0,'0,0,0);
    rst = 1'b1; #1;
    chk("m_rst_clr", meta_err, 0);
    #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vegeta_weight_loader.md
Name: vegeta_weight_loader

Overview:
- Upstream feeder for the vegeta_pu column chain.
- Accepts a valid/ready stream of packed N:M-sparse weight words (value + metadata per MAC lane) and shifts one tile of NUM_ROWS words into the PU chain via weight_out/weight_transferring_out.
- Drives the double-buffer select (i_wb of the PUs) and tracks occupancy of both weight buffers, so the compute controller never has a buffer overwritten while it is in use.

Parameters:
- BETA, 4, MAC lanes per PU.
- MUL_DATAWIDTH, 8, weight value width per lane.
- META_DATA_SIZE, 2, metadata width per lane.
- BLOCK_SIZE, 4, sparsity block size; legal metadata values are 0..BLOCK_SIZE-1.
- NUM_ROWS, 4, PU rows in the column; beats per tile load. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; request a tile load into buffer wb_sel_out.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat ready.
- s_data  in  BETA*(MUL_DATAWIDTH+META_DATA_SIZE)  weight beat. Lane i occupies [i*W +: W], W=MUL_DATAWIDTH+META_DATA_SIZE. Metadata is the upper META_DATA_SIZE bits of each lane.
- buf_release  in  1  pulse; compute side finished with a buffer.
- buf_release_sel  in  1  index of the buffer released.
- weight_out  out  same width as s_data  to first PU weight_in.
- weight_transferring_out  out  1  to PU weight_transferring_in.
- wb_sel_out  out  1  to PU i_wb; buffer being or next to be loaded.
- buf_full  out  2  per-buffer "loaded, not yet released" flags.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile completion.
- meta_err  out  1  sticky; illegal metadata seen.

Behaviour:
- Reset: all outputs 0 (weight_out=0, wb_sel_out=0, buf_full=2'b00, s_ready=0, meta_err=0); state IDLE; row counter 0.
- Reset asserted mid-load aborts immediately. Partially shifted PU contents are undefined; buf_full is cleared.
- FSM states: IDLE, WAIT_BUF, LOAD, DONE.
- IDLE: on start, go to LOAD if buf_full[wb_sel_out]==0, else WAIT_BUF.
- start in any other state is ignored (not queued).
- WAIT_BUF: go to LOAD in the cycle after buf_full[wb_sel_out] reads 0.
- LOAD behaviour:
  - s_ready=1 (registered, asserted the cycle after entering LOAD).
  - Each handshake (s_valid&s_ready) at cycle t registers s_data into weight_out and sets weight_transferring_out=1 at t+1.
  - Cycles with no handshake give weight_transferring_out=0 at the next cycle; weight_out holds its value.
  - Beat order: first beat is destined for the deepest row (NUM_ROWS-1); lanes are passed unmodified.
  - Row counter increments per handshake. On the NUM_ROWS-th handshake, s_ready drops the next cycle (no extra beat accepted) and the FSM goes to DONE.
- DONE (one cycle):
  - done=1, coinciding with the final weight_transferring_out=1.
  - buf_full[wb_sel_out] set.
  - Next cycle: wb_sel_out toggles, state returns to IDLE.
  - wb_sel_out never changes while in LOAD or DONE.
- buf_release: clears buf_full[buf_release_sel] if set; ignored if that buffer is already 0.
  - Same-cycle set (DONE) and release of the same buffer: the set wins, because that buffer was free before the set.
  - Release of the other buffer in the same cycle proceeds normally.
- meta_err: set at the handshake cycle+1 if any lane's metadata ≥ BLOCK_SIZE. Cleared only by rst. Data still passes through.
  - Cannot fire when BLOCK_SIZE == 2^META_DATA_SIZE.
- Latency: stream handshake to weight_out is 1 cycle. With back-to-back beats, one tile takes NUM_ROWS+2 cycles from start to done (plus WAIT_BUF cycles).

Test Plan:
- Basic tile: rst, start, 4 back-to-back beats 0x11..,0x22..,0x33..,0x44.. with s_valid=1 → weight_transferring_out high for 4 cycles, each 1 cycle after its beat. done pulses with the 0x44 output; buf_full=01; wb_sel_out=1 the next cycle.
- Gapped stream: s_valid pattern 1,0,0,1,1,0,1 → transferring follows the pattern delayed 1 cycle; weight_out holds during gaps; done after the 4th beat only.
- Buffer back-pressure: two full tiles give buf_full=11 and wb_sel_out=0. A third start → WAIT_BUF, s_ready=0. buf_release sel=0 → LOAD begins the following cycle.
- Release collisions: release sel=1 in the DONE cycle of a buffer-0 load → buf_full=01. Release of an already-free buffer → no change. start during LOAD → ignored; tile completes with exactly 4 beats.
- Metadata: BLOCK_SIZE=3, META=2; a lane with metadata 3 → meta_err=1 the next cycle and stays set; data still forwarded; only rst clears it.
- Reset mid-load: assert rst after beat 2 → all outputs 0 asynchronously, buf_full=00, wb_sel_out=0. A subsequent start and 4 beats complete normally.
